// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared md_op encodings and FSM state type for the multiply/divide unit
// Contents: md_op_e (operation codes), mdu_state_e (IDLE/CALC/FIN).
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between a requester and mul_div_unit
// Request: start, md_op[2:0], a_in, b_in. Result: busy, done, div_zero, hi_out, lo_out.
// master = requester side, slave = mul_div_unit side.
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, md_op, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, md_op, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - one-bit-per-cycle unsigned shift-add multiply / restoring divide datapath
// Ports: clk; load (capture magnitudes, clear accumulator); step (advance one bit);
// is_div (select divide step); a_mag/b_mag unsigned operands;
// hi_res/lo_res = product upper/lower half, or remainder/quotient, after WIDTH steps.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Multiply: add multiplicand when the current multiplier bit is set, then shift {acc,q} right.
    // Divide: shift the next dividend bit into the partial remainder and try subtracting.
    // The remainder stays below d, so shifted < 2*d fits in WIDTH+1 bits.
    always_comb begin
        add_sum = {1'b0, acc} + (q[0] ? {1'b0, d} : {(WIDTH+1){1'b0}});
        shifted = {acc, q[WIDTH-1]};
        diff    = shifted - {1'b0, d};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc <= '0;
            q   <= a_mag;
            d   <= b_mag;
        end else if (step) begin
            if (is_div) begin
                if (!diff[WIDTH]) begin
                    acc <= diff[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= shifted[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc <= add_sum[WIDTH:1];
                q   <= {add_sum[0], q[WIDTH-1:1]};
            end
        end
    end

    assign hi_res = acc;
    assign lo_res = q;
endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS-style multiply/divide unit with HI/LO registers
// Ports: clk, rst (synchronous, active-high); bus (mul_div_unit_if.slave):
// start/md_op/a_in/b_in request, busy, done and div_zero pulses, hi_out/lo_out registers.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    mul_div_unit_if.slave      bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e       state, state_nxt;
    md_op_e           op_in;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dz_q;
    logic             op_div_q, res_neg_q, rem_neg_q, zero_q;

    logic             is_arith, is_div_op, signed_op, b_zero, a_sgn, b_sgn, load;
    logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo;
    logic [2*WIDTH-1:0] prod;

    assign op_in     = md_op_e'(bus.md_op);
    assign is_arith  = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                       (op_in == OP_DIV)  || (op_in == OP_DIVU);
    assign is_div_op = (op_in == OP_DIV) || (op_in == OP_DIVU);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign b_zero    = (bus.b_in == '0);
    assign a_sgn     = signed_op & bus.a_in[WIDTH-1];
    assign b_sgn     = signed_op & bus.b_in[WIDTH-1];
    // The most-negative value negates to itself, which is already its correct unsigned magnitude.
    assign a_mag     = a_sgn ? -bus.a_in : bus.a_in;
    assign b_mag     = b_sgn ? -bus.b_in : bus.b_in;
    assign load      = (state == ST_IDLE) && bus.start && is_arith;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .load   (load),
        .step   (state == ST_CALC),
        .is_div (op_div_q),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .hi_res (core_hi),
        .lo_res (core_lo)
    );

    assign prod = res_neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (load) state_nxt = (is_div_op && b_zero) ? ST_FIN : ST_CALC;
            ST_CALC: if (cnt == LAST) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            op_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        op_div_q  <= is_div_op;
                        res_neg_q <= a_sgn ^ b_sgn;
                        rem_neg_q <= a_sgn;
                        zero_q    <= is_div_op && b_zero;
                        cnt       <= '0;
                    end else if (bus.start && op_in == OP_MTHI) begin
                        hi_q <= bus.a_in;
                    end else if (bus.start && op_in == OP_MTLO) begin
                        lo_q <= bus.a_in;
                    end
                end
                ST_CALC: cnt <= cnt + 1'b1;
                ST_FIN: begin
                    done_q <= 1'b1;
                    if (zero_q) begin
                        dz_q <= 1'b1;
                    end else if (op_div_q) begin
                        lo_q <= res_neg_q ? -core_lo : core_lo;
                        hi_q <= rem_neg_q ? -core_hi : core_hi;
                    end else begin
                        {hi_q, lo_q} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit at WIDTH=32
module tb_mul_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   lat;
    int   dcount;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request for one edge, scrambles operands afterwards, and returns the number
    // of cycles (counted from the cycle after the start edge) until done, or -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat_o);
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.a_in = a; bus.b_in = b;
        @(negedge clk);
        bus.start = 1'b0; bus.a_in = 32'hDEADBEEF; bus.b_in = 32'h0BADF00D;
        lat_o = -1;
        for (int n = 0; n <= 100; n++) begin
            if (bus.done === 1'b1) begin
                lat_o = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_pulse_end(input string tag);
        @(negedge clk);
        chk({tag, "_done_low"}, {63'd0, bus.done}, 64'd0);
        chk({tag, "_idle"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.md_op = 3'b000; bus.a_in = '0; bus.b_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_dz", {63'd0, bus.div_zero}, 64'd0);
        chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        rst = 1'b0;

        // multu max*max, including latency
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        chk("multu_lat", 64'(lat), 64'd33);
        chk("multu_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFFFFFE_00000001);
        chk("multu_dz", {63'd0, bus.div_zero}, 64'd0);
        chk_pulse_end("multu");

        run_op(3'b000, 32'hFFFFFFFE, 32'd3, lat);
        chk("mult_lat", 64'(lat), 64'd33);
        chk("mult_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFFFFFF_FFFFFFFA);

        run_op(3'b010, 32'hFFFFFFF9, 32'd2, lat);
        chk("div_neg_lat", 64'(lat), 64'd33);
        chk("div_neg_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(3'b010, 32'd7, 32'hFFFFFFFE, lat);
        chk("div_negb_hilo", {bus.hi_out, bus.lo_out}, 64'h00000001_FFFFFFFD);

        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, lat);
        chk("div_ovf_hilo", {bus.hi_out, bus.lo_out}, 64'h00000000_80000000);
        chk("div_ovf_dz", {63'd0, bus.div_zero}, 64'd0);

        run_op(3'b011, 32'd100, 32'd7, lat);
        chk("divu_hilo", {bus.hi_out, bus.lo_out}, 64'h00000002_0000000E);

        // mthi / mtlo: immediate write, never busy, no done
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'b100; bus.a_in = 32'h12345678;
        @(negedge clk);
        bus.md_op = 3'b101; bus.a_in = 32'h9ABCDEF0;
        chk("mthi_hi", {32'd0, bus.hi_out}, 64'h12345678);
        chk("mthi_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo_hilo", {bus.hi_out, bus.lo_out}, 64'h12345678_9ABCDEF0);
        chk("mtlo_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);

        // divide by zero: done one cycle after start, HI/LO untouched
        run_op(3'b011, 32'd100, 32'd0, lat);
        chk("dz_lat", 64'(lat), 64'd1);
        chk("dz_flag", {63'd0, bus.div_zero}, 64'd1);
        chk("dz_hilo", {bus.hi_out, bus.lo_out}, 64'h12345678_9ABCDEF0);
        @(negedge clk);
        chk("dz_pulse_end", {62'd0, bus.done, bus.div_zero}, 64'd0);

        // reserved op ignored
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'b110; bus.a_in = 32'h5; bus.b_in = 32'h3;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rsv_busy", {63'd0, bus.busy}, 64'd0);
        chk("rsv_hilo", {bus.hi_out, bus.lo_out}, 64'h12345678_9ABCDEF0);

        // multu, ignored divu at cycle 5, reset at cycle 10
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'b001; bus.a_in = 32'd5; bus.b_in = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.md_op = 3'b011; bus.a_in = 32'd1; bus.b_in = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort_busy_mid", {63'd0, bus.busy}, 64'd1);
        repeat (3) @(negedge clk);
        chk("abort_hilo_mid", {bus.hi_out, bus.lo_out}, 64'h12345678_9ABCDEF0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);

        // reset wins over a simultaneous start
        bus.start = 1'b1; bus.md_op = 3'b100; bus.a_in = 32'hAAAA5555;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_prio_hi", {32'd0, bus.hi_out}, 64'd0);
        chk("rst_prio_busy", {63'd0, bus.busy}, 64'd0);

        run_op(3'b001, 32'd3, 32'd5, lat);
        chk("post_rst_lat", 64'(lat), 64'd33);
        chk("post_rst_hilo", {bus.hi_out, bus.lo_out}, 64'h00000000_0000000F);
        chk_pulse_end("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
